uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit half of the FullUART. Accepts one parallel byte from the Tramelblaze (OUT_PORT path) and serialises it onto the line as a standard asynchronous frame, LSB first: start bit, 8 data bits, optional parity bit, 1 stop bit.
- Performs the parallel-in-serial-out counterpart of the receive shift register.
- Owns its own bit-time counter, bit counter and frame FSM.
- Reports readiness to the processor so it knows when the next byte may be written.

Parameters:
- BAUD_DIV, 868, clk cycles per bit time (100 MHz / 115200). Legal range 2..65535.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  write strobe; the byte on data_in is accepted when load=1 and tx_rdy=1
- data_in  input  8  byte to transmit
- tx  output  1  serial line; idles high
- tx_rdy  output  1  level; 1 = idle, can accept a load
- tx_done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset values:
  - tx=1, tx_rdy=1, tx_done=0.
  - FSM=IDLE; bit-time counter=0; bit counter=0; shift register = all ones.
- All outputs are registered. The reset is asynchronous: tx returns to 1 immediately, even mid-frame, and the partial frame is discarded.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - On load=1, at that clock edge: data_in is captured into the shift register, tx<=0, tx_rdy<=0, state->START, bit-time counter cleared.
  - load with tx_rdy=0 is ignored; data_in is not sampled.
- Bit-time counter:
  - Counts 0..BAUD_DIV-1 in every non-IDLE state.
  - "bit time up" = count==BAUD_DIV-1. The counter wraps to 0 on that cycle.
  - Each bit is driven for exactly BAUD_DIV clocks.
- START: on bit time up, tx<=shift[0], shift right with 1 filled in, state->DATA, bit counter=0.
- DATA:
  - On bit time up, if bit counter<7: output next shifted bit and increment the bit counter.
  - On bit time up with bit counter=7: go to PARITY (with the macro) or STOP, with tx<=parity or 1 respectively.
- PARITY: on bit time up, tx<=1, state->STOP.
- STOP: on bit time up, state->IDLE, tx stays 1, tx_rdy<=1, tx_done<=1 for exactly that one following cycle.
- Frame timing:
  - First tx low edge occurs 1 clk after the accepting load edge.
  - tx_rdy re-asserts FRAME_BITS*BAUD_DIV clks after tx falls. FRAME_BITS = 10, or 11 with parity.
- Back-to-back: a load in the first cycle tx_rdy=1 is accepted, giving a stop bit of exactly BAUD_DIV cycles followed by the next start bit with no idle gap.
- tx_done and load may coincide; that load is accepted normally.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is compiled in; frame is 11 bits.
  - Parity bit = ^data_in (captured at load), XOR PARITY_ODD.
- Undefined:
  - No PARITY state or parity logic; frame is 10 bits; PARITY_ODD is unused.

Decomposition:
- Shared package uart_pkg, which the receiver also uses:
  - FSM state encoding typedef.
  - DATA_BITS=8.
  - FRAME_BITS constants (with and without parity).
  - Default BAUD_DIV.
- One natural sub-module: uart_bit_timer.
  - Parameterised BAUD_DIV counter with enable and synchronous clear.
  - Emits the one-cycle bit-time-up pulse.
  - Reusable by the receiver for half-bit/full-bit timing.

Test Plan:
- Reset: assert reset for 3 cycles -> tx=1, tx_rdy=1, tx_done=0; release, no load for 100 cycles -> outputs unchanged.
- BAUD_DIV=4, load 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held exactly 4 clks; tx_rdy low 40 clks; single tx_done pulse.
- Busy load: load 0xA3, then load 0xFF at bit 3 -> frame still carries 0xA3 (LSB first: 1,1,0,0,0,1,0,1); 0xFF never sent.
- Back-to-back: load 0x00, then load 0xFF on the cycle tx_rdy rises -> stop bit exactly 4 clks, next start bit follows immediately.
- Reset mid-frame during DATA bit 5 -> tx=1 asynchronously, tx_rdy=1; a following load of 0x3C transmits a clean frame.
- UART_TX_PARITY_EN, PARITY_ODD=0: 0x07 -> parity bit 1, frame 11 bits = 44 clks; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive halves.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS_NOPAR = 10;  // start + 8 data + stop
  localparam int FRAME_BITS_PAR   = 11;  // start + 8 data + parity + stop
  localparam int DEFAULT_BAUD_DIV = 868; // 100 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts 0..BAUD_DIV-1 while enabled and pulses up_o on the
// last count, wrapping to zero on that same cycle. A synchronous clear holds it
// at zero. Shared with the receiver for half/full bit timing.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic up_o
);

  localparam int              CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign up_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise count and wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = up_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises one byte LSB first as start, 8 data bits,
// optional parity, one stop bit. All outputs are registered.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_rdy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if ((BAUD_DIV < 2) || (BAUD_DIV > 65535) || (PARITY_ODD < 0) || (PARITY_ODD > 1))
  begin : g_bad_param
    $error("uart_tx_engine: BAUD_DIV must be 2..65535 and PARITY_ODD 0 or 1");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        bit_up;
  logic        accept;

`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  // Only a load seen while idle is taken; data_in is ignored otherwise.
  assign accept = load && rdy_q;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q != ST_IDLE),
    .clr_i (state_q == ST_IDLE),
    .up_o  (bit_up)
  );

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame FSM next state: every non-idle state advances on a bit boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (bit_up) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (bit_up && bit_q == LAST_BIT) state_d = ST_PARITY;
      ST_PARITY: if (bit_up) state_d = ST_STOP;
`else
      ST_DATA:   if (bit_up && bit_q == LAST_BIT) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_up) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the shifter, bit counter and registered line outputs.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = data_in;
          bit_d   = '0;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^data_in) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (bit_up) begin
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[7:1]};
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_up) begin
          if (bit_q != LAST_BIT) begin
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
`else
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_up) tx_d = 1'b1;
      end
`endif
      ST_STOP: begin
        if (bit_up) begin
          tx_d   = 1'b1;
          rdy_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; reset drops any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '1;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_rdy  = rdy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table of directed frames, hand
// sequences for busy/back-to-back/mid-frame reset, then random bytes against a
// frame-level reference model.
module tb_uart_tx_engine;

  localparam int BD   = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk, reset, load;
  logic [7:0] data_in;
  logic       tx, tx_rdy, tx_done;

  int checks = 0;
  int errs   = 0;

  uart_tx_engine #(.BAUD_DIV(BD), .PARITY_ODD(PODD)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .tx      (tx),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  d;
    logic [10:0] f;   // line bits, index 0 is sent first
  } vec_t;

  vec_t tbl[6];

  // Packs a hand-written frame: start 0, data LSB first, [parity], stop 1.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {2'b01, d, 1'b0} | {10'b0, p & 1'b0};
`endif
  endfunction

  // Reference model: the frame as a list of line bits from the byte alone.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    f[9] = ((ones % 2) == 1) ^ (PODD != 0);
`endif
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_rdy(input string nm);
    int n;
    n = 0;
    while (tx_rdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " rdy wait"}, 32'(tx_rdy), 32'd1);
  endtask

  // Starts a frame at the current negedge and checks every cycle of it.
  // Returns at the negedge where tx_rdy/tx_done should be back high.
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp,
                           input string nm, input int busy_cyc);
    int bad;
    load    = 1'b1;
    data_in = d;
    @(negedge clk);
    load    = 1'b0;
    data_in = 8'($urandom);
    for (int b = 0; b < FB; b++) begin
      bad = 0;
      for (int c = 0; c < BD; c++) begin
        if ((b * BD + c) == busy_cyc) begin
          load    = 1'b1;
          data_in = 8'hFF;
        end else begin
          load = 1'b0;
        end
        if (tx !== exp[b] || tx_rdy !== 1'b0 || tx_done !== 1'b0) bad++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", nm, b), 32'(bad), 32'd0);
    end
    load = 1'b0;
    chk({nm, " end"}, {29'b0, tx_done, tx_rdy, tx}, 32'b111);
  endtask

  task automatic idle_check(input string nm, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_rdy !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'h55, mk(8'h55, 1'b0)};
    tbl[1] = '{8'h00, mk(8'h00, 1'b0)};
    tbl[2] = '{8'hFF, mk(8'hFF, 1'b0)};
    tbl[3] = '{8'h3C, mk(8'h3C, 1'b0)};
    tbl[4] = '{8'h07, mk(8'h07, 1'b1)};
    tbl[5] = '{8'h03, mk(8'h03, 1'b0)};

    // Reset state
    reset   = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset outputs", {29'b0, tx_done, tx_rdy, tx}, 32'b011);
    reset = 1'b0;
    idle_check("idle after reset", 100);

    // Directed frames from the table
    for (int i = 0; i < 6; i++) begin
      wait_rdy($sformatf("tbl%0d", i));
      run_frame(tbl[i].d, tbl[i].f, $sformatf("tbl%0d", i), -1);
      idle_check($sformatf("tbl%0d done pulse", i), 1);
    end

    // Busy load at data bit 3 must be ignored
    run_frame(8'hA3, mk(8'hA3, 1'b0), "busy", 4 * BD + 1);
    idle_check("busy no second frame", 3 * BD);

    // Back-to-back: second load on the first tx_rdy cycle
    run_frame(8'h00, mk(8'h00, 1'b0), "b2b first", -1);
    run_frame(8'hFF, mk(8'hFF, 1'b0), "b2b second", -1);
    idle_check("b2b idle", 2);

    // Asynchronous reset during data bit 5 (0x96 bit5 = 0)
    load    = 1'b1;
    data_in = 8'h96;
    @(negedge clk);
    load = 1'b0;
    repeat (6 * BD + 1) @(negedge clk);
    chk("pre-reset tx", 32'(tx), 32'd0);
    #1 reset = 1'b1;
    #1 chk("async reset", {29'b0, tx_done, tx_rdy, tx}, 32'b011);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(8'h3C, mk(8'h3C, 1'b0), "post-reset", -1);
    idle_check("post-reset idle", 1);

    // Random bytes with random gaps, some back-to-back
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int gap;
      d   = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_check($sformatf("rnd%0d gap", i), gap);
      run_frame(d, model_frame(d), $sformatf("rnd%0d(%02h)", i, d), -1);
    end
    idle_check("final idle", 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
